// File: rtl/uart_io_server_if.sv
// uart_io_server_if: exec-side UART request bus between a requester and uart_io_server.
interface uart_io_server_if;
  logic        order;
  logic [1:0]  size;
  logic [31:0] o_data;
  logic        write_flag;
  logic        accepted;
  logic        done;
  logic [31:0] i_data;
  modport master (output order, size, o_data, write_flag, input accepted, done, i_data);
  modport slave (input order, size, o_data, write_flag, output accepted, done, i_data);
endinterface

// File: rtl/uart_io_server.sv
// uart_io_server: serves one UART request at a time (write -> TX bytes, read <- RX FIFO).
// Define UART_IO_OVERRUN_EN to add the sticky rx_overrun flag for dropped RX bytes.
module uart_io_server #(
  parameter int RX_DEPTH     = 16,
  parameter int LOG_RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  uart_io_server_if.slave   bus,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid
`ifdef UART_IO_OVERRUN_EN
  ,
  output logic              rx_overrun
`endif
);
  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;
  localparam logic [LOG_RX_DEPTH:0] FULL = (LOG_RX_DEPTH+1)'(RX_DEPTH);
  state_t state, state_nx;
  logic [1:0] idx, last;
  logic [31:0] wdata, rdata;
  logic [7:0] mem [RX_DEPTH];
  logic [LOG_RX_DEPTH-1:0] wp, rp;
  logic [LOG_RX_DEPTH:0] cnt;
  logic push, pop, step, ovr_bit;
  always_comb begin
    state_nx     = state;
    bus.accepted = 1'b0;
    bus.done     = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = '0;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        bus.accepted = bus.order & rstn;
        state_nx     = bus.order ? (bus.write_flag ? SEND : RECV) : IDLE;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = wdata[{idx, 3'b0} +: 8];
        state_nx = (tx_ready && idx == last) ? DONE : SEND;
      end
      RECV: begin
        pop      = cnt != '0;
        state_nx = (pop && idx == last) ? DONE : RECV;
      end
      default: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
    endcase
    bus.i_data = bus.done ? rdata : '0;
  end
  // A full FIFO still takes a byte when a pop frees a slot in the same cycle.
  assign push = rx_valid & (cnt != FULL | pop);
  assign step = (state == SEND & tx_ready) | pop;
`ifdef UART_IO_OVERRUN_EN
  logic ovr;
  assign rx_overrun = ovr;
  assign ovr_bit    = ovr & ~bus.write_flag & ~bus.size[1];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ovr <= 1'b0;
    else if (rx_valid & ~push) ovr <= 1'b1;
    else if (bus.accepted & ~bus.write_flag) ovr <= 1'b0;
`else
  assign ovr_bit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
      last  <= '0;
      wdata <= '0;
      rdata <= '0;
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (bus.accepted) begin
        idx   <= '0;
        last  <= bus.size[1] ? 2'd3 : {1'b0, bus.size[0]};
        wdata <= bus.o_data;
        rdata <= {ovr_bit, 31'b0};
      end else if (step) idx <= idx + 2'd1;
      if (pop) begin
        rdata[{idx, 3'b0} +: 8] <= mem[rp];
        rp <= rp + 1'b1;
      end
      if (push) wp <= wp + 1'b1;
      cnt <= cnt + (LOG_RX_DEPTH+1)'(push) - (LOG_RX_DEPTH+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= rx_data;
endmodule

// File: tb/tb_uart_io_server.sv
// tb_uart_io_server: randomized self-checking bench for uart_io_server against a queue-based model.
module tb_uart_io_server;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  uart_io_server_if bus ();
  logic [7:0] tx_data, rx_data = 8'h00;
  logic tx_valid, tx_ready = 1'b1, rx_valid = 1'b0;
`ifdef UART_IO_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
  logic rx_overrun;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  uart_io_server #(.RX_DEPTH(16), .LOG_RX_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef UART_IO_OVERRUN_EN
    , .rx_overrun(rx_overrun)
`endif
  );
  int checks = 0, errors = 0, rdy_mode = 0, last_lat = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit ovr_m = 1'b0;
  // tx_ready: 0 = held high, 1 = random, 2 = held low; changes 2 time units after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (rstn && tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (bus.accepted && bus.done) begin
      errors++;
      $display("FAIL accepted_and_done: both high at %0t, required never together", $time);
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic push_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (rx_q.size() < 16) rx_q.push_back(b);
    else ovr_m = 1'b1;
  endtask
  task automatic do_req(input logic wf, input logic [1:0] sz, input logic [31:0] od,
                        output logic [31:0] res, output int lat, output bit ok);
    bus.order = 1'b1; bus.write_flag = wf; bus.size = sz; bus.o_data = od;
    ok = 1'b0; lat = 0; res = 'x;
    @(negedge clk);
    for (int i = 0; i < 200 && !bus.accepted; i++) @(negedge clk);
    if (!bus.accepted) begin
      bus.order = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.order = 1'b0;
    lat = 1;
    @(negedge clk);
    for (int i = 0; i < 2000 && !bus.done; i++) begin
      @(negedge clk);
      lat++;
    end
    if (bus.done) begin
      res = bus.i_data;
      ok  = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [1:0] sz, input logic [31:0] d, input string nm);
    logic [31:0] res;
    int lat, n;
    bit ok, bad;
    tx_q.delete();
    do_req(1'b1, sz, d, res, lat, ok);
    last_lat = lat;
    n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    bad = !ok || res !== 32'h0 || tx_q.size() != n;
    for (int i = 0; i < n && !bad; i++) if (tx_q[i] !== d[8*i +: 8]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: done=%0d i_data=%h bytes_sent=%0d first=%h, required done i_data=0 %0d bytes of %h",
               nm, ok, res, tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00, n, d);
    end
  endtask
  task automatic do_read(input logic [1:0] sz, input string nm);
    logic [31:0] res, exp;
    int lat, n;
    bit ok, f;
    f = OVR_EN && ovr_m && sz < 2;
    do_req(1'b0, sz, $urandom, res, lat, ok);
    last_lat = lat;
    ovr_m = 1'b0;
    n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    exp = '0;
    for (int i = 0; i < n; i++) if (rx_q.size() != 0) exp[8*i +: 8] = rx_q.pop_front();
    if (f) exp[31] = 1'b1;
    checks++;
    if (!ok || res !== exp) begin
      errors++;
      $display("FAIL %s: done=%0d i_data=%h, required %h", nm, ok, res, exp);
    end
  endtask
  task automatic test_reset;
    bus.order = 1'b1; bus.write_flag = 1'b1; bus.size = 2'd0; bus.o_data = 32'h0000005A;
    tx_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.accepted, bus.done, tx_valid} !== 3'b000 || bus.i_data !== 0 || tx_data !== 0) begin
        errors++;
        $display("FAIL reset_outputs: acc/done/txv=%b i_data=%h tx_data=%h, required all 0",
                 {bus.accepted, bus.done, tx_valid}, bus.i_data, tx_data);
      end
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.accepted !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_accept: accepted=%b, required 1", bus.accepted);
    end
    @(posedge clk);
    #1;
    bus.order = 1'b0;
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    checks++;
    if (!bus.done || tx_q.size() != 1 || tx_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL reset_first_write: done=%b bytes=%0d, required done with single byte 5a",
               bus.done, tx_q.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_write_burst;
    rdy_mode = 0;
    do_write(2'd2, 32'hA1B2C3D4, "write_burst");
    checks++;
    if (last_lat != 5) begin
      errors++;
      $display("FAIL write_burst_latency: %0d cycles, required 5", last_lat);
    end
    do_write(2'd3, 32'h01020304, "write_size3");
  endtask
  task automatic test_write_stall;
    bit seen;
    rdy_mode = 2;
    @(posedge clk);
    #1;
    tx_q.delete();
    bus.order = 1'b1; bus.write_flag = 1'b1; bus.size = 2'd0; bus.o_data = 32'hFFFFFF55;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.order = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
        errors++;
        $display("FAIL write_stall_hold: tx_valid=%b tx_data=%h, required 1 and 55", tx_valid, tx_data);
      end
    end
    rdy_mode = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = tx_valid && tx_ready;
    end
    @(negedge clk);
    checks++;
    if (!seen || bus.done !== 1'b1 || bus.i_data !== 0 || tx_q.size() != 1) begin
      errors++;
      $display("FAIL write_stall_done: handshake=%0d done=%b i_data=%h bytes=%0d, required 1 1 0 1",
               seen, bus.done, bus.i_data, tx_q.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_read_stall;
    fork
      do_read(2'd1, "read_stall");
      begin
        repeat (10) @(posedge clk);
        #1;
        push_rx(8'h34);
        push_rx(8'h12);
      end
    join
    checks++;
    if (last_lat <= 10) begin
      errors++;
      $display("FAIL read_stall_wait: done after %0d cycles, required more than 10", last_lat);
    end
  endtask
  task automatic test_overflow;
    for (int i = 0; i < 17; i++) push_rx(8'(i));
    @(negedge clk);
`ifdef UART_IO_OVERRUN_EN
    checks++;
    if (rx_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: rx_overrun=%b, required 1", rx_overrun);
    end
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      do_read(2'd2, "overflow_read");
`ifdef UART_IO_OVERRUN_EN
      checks++;
      if (rx_overrun !== 1'b0) begin
        errors++;
        $display("FAIL overrun_clear: rx_overrun=%b, required 0", rx_overrun);
      end
`endif
    end
  endtask
  task automatic test_overrun_force;
    for (int i = 0; i < 17; i++) push_rx(8'($urandom));
    do_read(2'd0, "overrun_force_read");
    do_read(2'd2, "overrun_drain");
    do_read(2'd2, "overrun_drain");
    do_read(2'd2, "overrun_drain");
    do_read(2'd1, "overrun_drain");
    do_read(2'd0, "overrun_drain");
  endtask
  task automatic test_reset_mid_send;
    logic [31:0] d;
    d = $urandom;
    rdy_mode = 0;
    tx_q.delete();
    bus.order = 1'b1; bus.write_flag = 1'b1; bus.size = 2'd2; bus.o_data = d;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.order = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.accepted, bus.done, tx_valid} !== 3'b000 || tx_data !== 0 || bus.i_data !== 0) begin
      errors++;
      $display("FAIL reset_mid_send: acc/done/txv=%b tx_data=%h i_data=%h, required all 0",
               {bus.accepted, bus.done, tx_valid}, tx_data, bus.i_data);
    end
    checks++;
    if (tx_q.size() != 2 || tx_q[0] !== d[7:0] || tx_q[1] !== d[15:8]) begin
      errors++;
      $display("FAIL reset_mid_send_bytes: %0d bytes sent, required 2 (%h %h)", tx_q.size(), d[7:0], d[15:8]);
    end
    rx_q.delete();
    ovr_m = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    fork
      do_read(2'd0, "read_after_reset");
      begin
        repeat (3) @(posedge clk);
        #1;
        push_rx(8'h7E);
      end
    join
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) push_rx(8'($urandom));
    do_read(2'd2, "b2b_read4");
    checks++;
    if (last_lat != 5) begin
      errors++;
      $display("FAIL b2b_read4_latency: %0d cycles, required 5", last_lat);
    end
    push_rx(8'($urandom));
    do_read(2'd0, "b2b_read1");
    checks++;
    if (last_lat != 2) begin
      errors++;
      $display("FAIL b2b_read1_latency: %0d cycles, required 2", last_lat);
    end
  endtask
  task automatic test_random;
    for (int it = 0; it < 30; it++) begin
      logic [1:0] sz;
      int n, k;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        rdy_mode = 1;
        do_write(sz, $urandom, "random_write");
        rdy_mode = 0;
      end else begin
        n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
        k = $urandom_range(0, n);
        for (int i = 0; i < k; i++) push_rx(8'($urandom));
        fork
          do_read(sz, "random_read");
          for (int i = k; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            push_rx(8'($urandom));
          end
        join
      end
    end
  endtask
  initial begin
    bus.order = 1'b0; bus.write_flag = 1'b0; bus.size = 2'd0; bus.o_data = '0;
    test_reset();
    test_write_burst();
    test_write_stall();
    test_read_stall();
    test_overflow();
    if (OVR_EN) test_overrun_force();
    test_reset_mid_send();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
